// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, execute redirect and decode handshake.
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, sequential fetches to 1-cycle imem, DEPTH-entry queue to decode.
// Optional FETCH_BYPASS_EN: a response into an empty queue goes straight to decode in the same cycle.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            infl_q, infl_d, drop_q, drop_d;

  logic [ILEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  logic [CW:0]     occ;
  logic            req, accept, resp, head_v, byp, push, pop, out_v;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            unused_ok;

  assign unused_ok = ^bus.redirect_pc[1:0];

  always_comb begin
    // the in-flight fetch already owns a queue slot, so a push can never overflow
    occ    = {1'b0, cnt_q} + (CW+1)'(infl_q);
    req    = !rst && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));
    accept = req && bus.imem_ready;
    resp   = bus.imem_rvalid && !drop_q;
    head_v = (cnt_q != '0);
`ifdef FETCH_BYPASS_EN
    byp    = resp && !head_v && bus.inst_ready && !bus.redirect_valid;
`else
    byp    = 1'b0;
`endif
    push   = resp && !byp && !bus.redirect_valid;
    pop    = head_v && bus.inst_ready && !bus.redirect_valid;
    out_v  = !bus.redirect_valid && (head_v || byp);

    inst_o    = '0;
    inst_pc_o = '0;
    if (out_v) begin
      inst_o    = byp ? bus.imem_rdata : q_inst[rd_q];
      inst_pc_o = byp ? ipc_q          : q_pc[rd_q];
    end

    pc_d   = accept ? pc_q + XLEN'(4) : pc_q;
    ipc_d  = accept ? pc_q : ipc_q;
    infl_d = accept || (infl_q && !bus.imem_rvalid);
    drop_d = 1'b0;
    rd_d   = pop  ? rd_q + PW'(1) : rd_q;
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);

    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_d = infl_q;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ipc_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      infl_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ipc_q  <= ipc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_q] <= bus.imem_rdata;
      q_pc[wr_q]   <= ipc_q;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = out_v;
  assign bus.inst       = inst_o;
  assign bus.inst_pc    = inst_pc_o;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle instruction memory returning addr ^ A5A5_0000.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0, checks = 0, pops = 0, acc = 0;
  logic [31:0] exp_pc = '0, exp_addr = '0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();
  fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // memory responds exactly one cycle after each accept
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      bus.imem_rvalid <= bus.imem_req && bus.imem_ready;
      bus.imem_rdata  <= bus.imem_addr ^ KEY;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb(input string tag);
    #1;
    if (bus.inst_valid && bus.inst_ready) begin
      chk({tag, "_pc"}, bus.inst_pc, exp_pc);
      chk({tag, "_inst"}, bus.inst, exp_pc ^ KEY);
      exp_pc += 32'd4;
      pops++;
    end
  endtask

  initial begin
    bus.imem_ready     = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);

    // sequential stream from reset
    tick(); rst = 1'b0; exp_pc = 32'h0; pops = 0;
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick(); sb("seq");
    chk("lat_n1", {31'd0, bus.inst_valid}, {31'd0, BYP});
    tick(); sb("seq");
    chk("lat_n2", {31'd0, bus.inst_valid}, 32'd1);
    repeat (6) begin tick(); sb("seq"); end
    chk("seq_pops", pops, BYP ? 32'd8 : 32'd7);

    // decode stalled from an empty queue: 4 accepts then back-pressure
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; bus.inst_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1;
      if (bus.imem_req && bus.imem_ready) acc++;
    end
    chk("full_acc", acc, 32'd4);
    chk("full_req", {31'd0, bus.imem_req}, 32'd0);
    chk("full_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("full_head", bus.inst_pc, 32'h0);
    exp_pc = 32'h0; pops = 0;
    tick(); bus.inst_ready = 1'b1; sb("drain");
    repeat (8) begin tick(); sb("drain"); end
    chk("drain_pops", pops, 32'd9);

    // redirect while a fetch is in flight
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_req0", {31'd0, bus.imem_req}, 32'd0);
    chk("rd_valid0", {31'd0, bus.inst_valid}, 32'd0);
    tick(); bus.redirect_valid = 1'b0; exp_pc = 32'h100; pops = 0;
    #1;
    chk("rd_addr", bus.imem_addr, 32'h100);
    chk("rd_req1", {31'd0, bus.imem_req}, 32'd1);
    chk("rd_valid1", {31'd0, bus.inst_valid}, 32'd0);
    tick(); sb("rd");
    chk("rd_lat2", {31'd0, bus.inst_valid}, {31'd0, BYP});
    tick(); sb("rd");
    chk("rd_lat3", {31'd0, bus.inst_valid}, 32'd1);
    repeat (4) begin tick(); sb("rd"); end
    chk("rd_pops", pops, BYP ? 32'd6 : 32'd5);

    // back-to-back redirects: last one wins
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    tick(); bus.redirect_pc = 32'h0000_0305;
    tick(); bus.redirect_valid = 1'b0; exp_pc = 32'h304; pops = 0;
    #1;
    chk("bb_addr", bus.imem_addr, 32'h304);
    chk("bb_valid", {31'd0, bus.inst_valid}, 32'd0);
    repeat (5) begin tick(); sb("bb"); end
    chk("bb_pops", pops, BYP ? 32'd5 : 32'd4);

    // imem_ready pattern 1,0,0,1: pc moves only on accepts
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0400;
    exp_pc = 32'h400; exp_addr = 32'h400; pops = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); bus.redirect_valid = 1'b0; bus.imem_ready = pat[i % 4];
      sb("tog");
      chk("tog_addr", bus.imem_addr, exp_addr);
      if (bus.imem_req && bus.imem_ready) exp_addr += 32'd4;
    end
    chk("tog_pops", pops, 32'd5);

    // async reset mid-cycle with a full queue
    tick(); bus.imem_ready = 1'b1; bus.inst_ready = 1'b0;
    repeat (8) tick();
    chk("ar_full", {31'd0, bus.inst_valid}, 32'd1);
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("ar_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    chk("ar_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ar_inst", bus.inst, 32'h0);
    tick(); tick(); rst = 1'b0; bus.inst_ready = 1'b1; exp_pc = 32'h0; pops = 0;
    sb("ar");
    chk("ar_req1", {31'd0, bus.imem_req}, 32'd1);
    chk("ar_addr1", bus.imem_addr, 32'h0);
    repeat (8) begin tick(); sb("ar"); end
    chk("ar_pops", pops, BYP ? 32'd8 : 32'd7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
